// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with per-set LRU, req/ack line refill and flush.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_2way #(
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [31:0]                 pc,
  input  logic                        pc_valid,
  input  logic                        flush,
  output logic [31:0]                 instr,
  output logic                        instr_valid,
  output logic                        stall,
  output logic                        mem_req,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ack,
  input  logic [32*WORDS_PER_LINE-1:0] mem_words,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_next;

  logic [NUM_SETS-1:0] valid0, valid1, lru;
  logic [TAG_W-1:0]    tag0 [NUM_SETS];
  logic [TAG_W-1:0]    tag1 [NUM_SETS];
  logic [LINE_W-1:0]   data0 [NUM_SETS];
  logic [LINE_W-1:0]   data1 [NUM_SETS];
  logic                discard;

  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag, fill_tag;
  logic              hit0, hit1, hit, miss, fill_way, write_fill;
  logic [31:0]       word0, word1;
  logic              unused_byte_bits;

  assign word     = pc[OFF_W-1:2];
  assign idx      = pc[OFF_W+IDX_W-1:OFF_W];
  assign tag      = pc[31:OFF_W+IDX_W];
  assign fill_idx = mem_addr[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = mem_addr[31:OFF_W+IDX_W];
  assign unused_byte_bits = ^pc[1:0];

  assign hit0  = valid0[idx] && (tag0[idx] == tag);
  assign hit1  = valid1[idx] && (tag1[idx] == tag);
  assign hit   = pc_valid && (state == IDLE) && (hit0 || hit1);
  assign miss  = pc_valid && (state == IDLE) && !(hit0 || hit1);
  assign word0 = data0[idx][{word, 5'b0} +: 32];
  assign word1 = data1[idx][{word, 5'b0} +: 32];

  assign instr_valid = hit;
  assign instr       = hit ? (hit0 ? word0 : word1) : 32'h0000_0013;
  assign stall       = miss || (state == REFILL);

  // Refill handshake: mem_req is high for every REFILL cycle; mem_ack is a
  // one-cycle pulse carrying mem_words and is only honoured while in REFILL.
  assign mem_req = (state == REFILL);

  // Victim: first invalid way, otherwise the way LRU names.
  assign fill_way   = valid0[fill_idx] ? (valid1[fill_idx] ? lru[fill_idx] : 1'b1) : 1'b0;
  assign write_fill = (state == REFILL) && mem_ack && !discard && !flush;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss) state_next = REFILL;
      REFILL:  if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      valid0   <= '0;
      valid1   <= '0;
      lru      <= '0;
      discard  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state <= state_next;
      if (miss) mem_addr <= {pc[31:OFF_W], {OFF_W{1'b0}}};
      if (hit) lru[idx] <= hit0;
      if (write_fill) begin
        if (fill_way) valid1[fill_idx] <= 1'b1;
        else          valid0[fill_idx] <= 1'b1;
        lru[fill_idx] <= ~fill_way;
      end
      if (state == REFILL) begin
        if (mem_ack)    discard <= 1'b0;
        else if (flush) discard <= 1'b1;
      end
      // Flush wins over any same-cycle hit/fill update of valid and LRU.
      if (flush) begin
        valid0 <= '0;
        valid1 <= '0;
        if (state == IDLE) lru <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (write_fill) begin
      if (fill_way) begin
        tag1[fill_idx]  <= fill_tag;
        data1[fill_idx] <= mem_words;
      end else begin
        tag0[fill_idx]  <= fill_tag;
        data0[fill_idx] <= mem_words;
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (instr_valid && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if (miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Self-checking bench for icache_2way: table of fetches plus hand-written flush/reset sequences.
module tb_icache_2way;
  localparam int WPL = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [31:0]       pc;
  logic              pc_valid, flush, mem_ack;
  logic [32*WPL-1:0] mem_words;
  logic [31:0]       instr, mem_addr, hit_count, miss_count;
  logic              instr_valid, stall, mem_req;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          k;
  } vec_t;
  vec_t vecs[14];

  icache_2way #(.NUM_SETS(16), .WORDS_PER_LINE(WPL)) dut (
    .CLK(CLK), .RST(RST), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_words(mem_words), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  function automatic logic [32*WPL-1:0] line_of(input logic [31:0] a);
    logic [32*WPL-1:0] l;
    for (int i = 0; i < WPL; i++) l[32*i +: 32] = model(a) + i;
    return l;
  endfunction

  // Scoreboard: every cycle with a valid instruction consumes one expected word.
  always @(negedge CLK) begin
    if (instr_valid) begin
      if (exp_q.size() == 0) check("unexpected_hit", {31'b0, instr_valid}, 32'd0);
      else check("instr", instr, exp_q.pop_front());
    end else begin
      check("nop_when_invalid", instr, 32'h0000_0013);
    end
  end

  task automatic idle_cycle();
    @(posedge CLK); #1;
    pc_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    @(negedge CLK);
  endtask

  // One fetch; on a miss the line is acked in cycle N+k and the N+k+1 hit is checked.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int k);
    logic [31:0] line_a;
    int stalls;
    line_a = addr & ~32'h1F;
    @(posedge CLK); #1;
    pc = addr; pc_valid = 1'b1;
    if (exp_hit) exp_q.push_back(model(addr));
    @(negedge CLK);
    check("stall", {31'b0, stall}, {31'b0, !exp_hit});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_hit});
    if (!exp_hit) begin
      stalls = 1;
      for (int c = 1; c <= k; c++) begin
        @(posedge CLK); #1;
        if (c == k) begin
          mem_ack = 1'b1;
          mem_words = line_of(line_a);
        end
        @(negedge CLK);
        check("mem_req", {31'b0, mem_req}, 32'd1);
        check("mem_addr", mem_addr, line_a);
        if (stall) stalls++;
      end
      @(posedge CLK); #1;
      mem_ack = 1'b0;
      exp_q.push_back(model(addr));
      @(negedge CLK);
      check("stall_after_fill", {31'b0, stall}, 32'd0);
      check("mem_req_drop", {31'b0, mem_req}, 32'd0);
      check("stall_cycles", stalls, k + 1);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0000, 1'b0, 3};
    vecs[1]  = '{32'h0000_0004, 1'b1, 0};
    vecs[2]  = '{32'h0000_001C, 1'b1, 0};
    vecs[3]  = '{32'h0000_0010, 1'b1, 0};
    vecs[4]  = '{32'h0000_0200, 1'b0, 1};
    vecs[5]  = '{32'h0000_0000, 1'b1, 0};
    vecs[6]  = '{32'h0000_0400, 1'b0, 2};
    vecs[7]  = '{32'h0000_0004, 1'b1, 0};
    vecs[8]  = '{32'h0000_0200, 1'b0, 1};
    vecs[9]  = '{32'h0000_0000, 1'b1, 0};
    vecs[10] = '{32'h0000_0024, 1'b0, 2};
    vecs[11] = '{32'h0000_003C, 1'b1, 0};
    vecs[12] = '{32'h1234_5678, 1'b0, 1};
    vecs[13] = '{32'h1234_5664, 1'b1, 0};

    RST = 1'b1; pc = '0; pc_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_words = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);

    // Cold miss followed by hits in the same line; counters cover 1 miss and 4 hits.
    for (int i = 0; i < 4; i++) fetch(vecs[i].addr, vecs[i].hit, vecs[i].k);
    idle_cycle();
`ifdef ICACHE_PERF_CNT_EN
    check("hit_count", hit_count, 32'd4);
    check("miss_count", miss_count, 32'd1);
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
`endif

    // Associativity and LRU replacement within set 0, then other sets.
    for (int i = 4; i < 14; i++) fetch(vecs[i].addr, vecs[i].hit, vecs[i].k);
    idle_cycle();

    // Flush in IDLE: the same-cycle hit is still returned, the next access misses.
    @(posedge CLK); #1;
    pc = 32'h0; pc_valid = 1'b1; flush = 1'b1;
    exp_q.push_back(model(32'h0));
    @(negedge CLK);
    check("flush_idle_hit", {31'b0, instr_valid}, 32'd1);
    idle_cycle();
    fetch(32'h0, 1'b0, 1);
    idle_cycle();

    // Flush during REFILL: first ack is discarded, a second request is issued.
    @(posedge CLK); #1;
    pc = 32'h0000_0400; pc_valid = 1'b1;
    @(negedge CLK);
    check("fr_stall", {31'b0, stall}, 32'd1);
    @(posedge CLK); #1;
    flush = 1'b1;
    @(negedge CLK);
    check("fr_mem_req", {31'b0, mem_req}, 32'd1);
    @(posedge CLK); #1;
    flush = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < WPL; i++) mem_words[32*i +: 32] = 32'hDEAD_0000 + i;
    @(negedge CLK);
    check("fr_stall_ack", {31'b0, stall}, 32'd1);
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    @(negedge CLK);
    check("fr_remiss_stall", {31'b0, stall}, 32'd1);
    check("fr_remiss_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("fr_req2", {31'b0, mem_req}, 32'd1);
    check("fr_addr2", mem_addr, 32'h0000_0400);
    @(posedge CLK); #1;
    mem_ack = 1'b1; mem_words = line_of(32'h0000_0400);
    @(negedge CLK);
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    exp_q.push_back(model(32'h0000_0400));
    @(negedge CLK);
    check("fr_fill_stall", {31'b0, stall}, 32'd0);
    idle_cycle();

    // Reset mid-refill, then a stray ack in IDLE that must be ignored.
    @(posedge CLK); #1;
    pc = 32'h0000_0800; pc_valid = 1'b1;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rr_mem_req", {31'b0, mem_req}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1; pc_valid = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rr_req_dropped", {31'b0, mem_req}, 32'd0);
    check("rr_mem_addr", mem_addr, 32'd0);
    check("rr_hit_count", hit_count, 32'd0);
    @(posedge CLK); #1;
    mem_ack = 1'b1; mem_words = line_of(32'h0000_0800);
    @(negedge CLK);
    check("rr_stray_req", {31'b0, mem_req}, 32'd0);
    idle_cycle();
    fetch(32'h0000_0800, 1'b0, 1);
    fetch(32'h0, 1'b0, 2);
    idle_cycle();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
